gf256_div_seq: RTL
==================

// Module: gf256_div_seq
// PURPOSE
// - Sequential GF(2^8) divider: q = a * b^-1. It is the inverse direction of the gf256_mult block.
// - Intended users: inverse-MixColumns checking, key-schedule/S-box inversion, ECC syndrome normalisation.
// - Computes b^-1 as b^254 = prod(b^(2^k), k=1..7), using 7 square-and-multiply iterations.
//   A final multiply by a gives q.
// - valid/ready handshake on both sides; one operation in flight at a time.
// PARAMETERS
// - POLY  8'h1B  low 8 bits of the field polynomial (x^8 implied).
//                8'h1B gives the AES field x^8+x^4+x^3+x+1.
// PORTS
// - clk          in   1  rising-edge clock
// - rst_n        in   1  asynchronous active-low reset
// - in_valid     in   1  operands a, b presented
// - in_ready     out  1  block can accept operands
// - a            in   8  dividend
// - b            in   8  divisor
// - out_valid    out  1  result valid
// - out_ready    in   1  consumer accepts result
// - q            out  8  quotient a/b
// - div_by_zero  out  1  set with out_valid when b==0
// BEHAVIOUR
// - Clocking: one clock (clk); reset is asynchronous and active-low (rst_n).
// - Reset values:
//   - state=IDLE, in_ready=1, out_valid=0, q=8'h00, div_by_zero=0.
//   - Internal s, r, a_q and cnt are all 0.
// - States: IDLE -> INV -> MUL -> DONE -> IDLE.
// - IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: latch a_q=a, s=b, r=8'h01, dz=(b==0), cnt=0; go to INV.
// - INV, one edge per iteration:
//   - s <= s*s (GF square); r <= r*(s*s).
//   - cnt <= cnt+1.
//   - After the 7th iteration (cnt==6 at the edge), go to MUL.
// - MUL, one edge:
//   - q <= dz ? 8'h00 : r*a_q.
//   - div_by_zero <= dz; out_valid <= 1; go to DONE.
// - DONE:
//   - q, div_by_zero and out_valid are held stable until out_ready.
//   - On out_valid&&out_ready: out_valid <= 0; go to IDLE.
//   - q keeps its last value.
// - Latency: out_valid rises on the 8th rising edge after the accepting edge.
// - Throughput: 1 op per 10 cycles when out_ready is held high.
// - in_ready is 0 in INV, MUL and DONE. Operands are never accepted while busy.
//   a and b may change freely after acceptance.
// - Boundary cases:
//   - b==0: the same 9-cycle schedule runs; q=0, div_by_zero=1.
//   - a==0: q=0, div_by_zero=0 (unless b==0).
//   - b==1: q=a.
// - Reset asserted mid-operation: immediate return to reset values. The partial result is discarded.
//   No spurious out_valid after reset is released.
// - Arithmetic is pure XOR / shift-reduce with POLY. Every value is 8 bits; there is no carry.
// STRUCTURE
// - Shared package gf256_pkg:
//   - GF256_POLY_AES = 8'h1B.
//   - State enum {IDLE, INV, MUL, DONE}.
//   - Function gf_mul(a, b, poly), a combinational shift-xor loop.
// - Sub-module gf256_mul_core #(POLY): combinational 8x8 GF multiply.
//   - Instance 1: s*s.
//   - Instance 2: r*(s*s), shared with r*a_q via an operand mux in MUL.
// - Top level: FSM, 3-bit iteration counter, operand/result registers.
// TESTING
// - Reference model: the same shift-xor gf_mul. It checks q*b==a for every b!=0.
// 1) a=01,b=53 -> q=CA, dz=0.
//    out_valid rises exactly 8 edges after acceptance; in_ready=0 meanwhile.
// 2) a=C1,b=83 -> q=57. Also a=57,b=01 -> q=57, and a=00,b=9A -> q=00.
// 3) a=3C,b=00 -> q=00, div_by_zero=1. The next op a=02,b=02 -> q=01, dz=0.
// 4) Backpressure: out_ready=0 for 5 cycles in DONE -> q, dz and out_valid are stable.
//    in_ready=0 and in_valid pulses are ignored. Release -> one handshake, then IDLE.
// 5) Reset: rst_n low in INV at cnt=3 -> outputs go to reset values asynchronously.
//    After release, a=0E,b=09 completes with the correct q=gf_mul(0E,inv(09)).
// 6) Sweep: all b in 01..FF with random a, out_ready random 50% -> q*b==a; zero mismatches.

Source files
------------

// File: rtl/gf256_pkg.sv
// gf256_pkg
// Shared definitions for the GF(2^8) arithmetic blocks.
//   GF256_POLY_AES : low 8 bits of the AES field polynomial x^8+x^4+x^3+x+1
//   state_t        : sequencing states of the divider
//   gf_mul         : combinational shift-xor multiply in GF(2^8)
package gf256_pkg;

    localparam logic [7:0] GF256_POLY_AES = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Russian-peasant multiply: walk the bits of y, accumulating x and
    // doubling it each step; doubling overflows past x^7 are folded back
    // in by XORing the reduction polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic [7:0] poly);
        logic [7:0] acc;
        logic [7:0] xx;
        acc = 8'h00;
        xx  = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                acc = acc ^ xx;
            end
            if (xx[7]) begin
                xx = {xx[6:0], 1'b0} ^ poly;
            end else begin
                xx = {xx[6:0], 1'b0};
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf256_div_seq_if.sv
// gf256_div_seq_if
// Operand/result handshake bundle for the GF(2^8) divider.
//   in_valid/in_ready   : operand handshake (a, b)
//   out_valid/out_ready : result handshake (q, div_by_zero)
// Modports: master = producer/consumer side, slave = divider side.
interface gf256_div_seq_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q;
    logic       div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, div_by_zero
    );

endinterface

// File: rtl/gf256_mul_core.sv
// gf256_mul_core
// Purely combinational 8x8 multiply in GF(2^8) reduced by POLY.
//   x, y : operands
//   p    : product
module gf256_mul_core
    import gf256_pkg::*;
#(
    parameter logic [7:0] POLY = GF256_POLY_AES
) (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] p
);

    assign p = gf_mul(x, y, POLY);

endmodule

// File: rtl/gf256_div_seq.sv
// gf256_div_seq
// Sequential GF(2^8) divider, q = a * b^-1.
// b^-1 is formed as b^254 = b^2 * b^4 * ... * b^128 by seven
// square-and-multiply steps, then one more multiply by a.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of gf256_div_seq_if
//           (in_valid/in_ready/a/b in, out_valid/out_ready/q/div_by_zero out)
module gf256_div_seq
    import gf256_pkg::*;
#(
    parameter logic [7:0] POLY = GF256_POLY_AES
) (
    input  logic            clk,
    input  logic            rst_n,
    gf256_div_seq_if.slave  bus
);

    state_t     state;
    state_t     state_next;

    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] a_q;
    logic [2:0] cnt;
    logic       dz;

    logic [7:0] q_r;
    logic       div_by_zero_r;
    logic       out_valid_r;
    logic       in_ready_c;

    logic [7:0] sq;
    logic [7:0] mul_y;
    logic [7:0] prod;

    // s*s feeds both the next s and the running product.
    gf256_mul_core #(.POLY(POLY)) u_square (
        .x (s),
        .y (s),
        .p (sq)
    );

    // The second multiplier does r*(s*s) while inverting and is reused
    // for r*a_q in the final step.
    assign mul_y = (state == MUL) ? a_q : sq;

    gf256_mul_core #(.POLY(POLY)) u_product (
        .x (r),
        .y (mul_y),
        .p (prod)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; in_ready is simply "sitting in IDLE".
    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = INV;
                end
            end
            INV: begin
                if (cnt == 3'd6) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, the seven squaring steps, the final
    // multiply and holding the result until the consumer takes it.
    // b==0 still runs the full schedule; dz just forces the result to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s             <= 8'h00;
            r             <= 8'h00;
            a_q           <= 8'h00;
            cnt           <= 3'd0;
            dz            <= 1'b0;
            q_r           <= 8'h00;
            div_by_zero_r <= 1'b0;
            out_valid_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q <= bus.a;
                        s   <= bus.b;
                        r   <= 8'h01;
                        dz  <= (bus.b == 8'h00);
                        cnt <= 3'd0;
                    end
                end
                INV: begin
                    s   <= sq;
                    r   <= prod;
                    cnt <= cnt + 3'd1;
                end
                MUL: begin
                    q_r           <= dz ? 8'h00 : prod;
                    div_by_zero_r <= dz;
                    out_valid_r   <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_r;
    assign bus.q           = q_r;
    assign bus.div_by_zero = div_by_zero_r;

endmodule
